// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// bus widths, legal latency bounds and the FSM state encoding.
package mem_arb_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported, fixed-latency memory between
// an instruction-fetch port and a data port; one access every MEM_LAT cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be within 1..8");
  end

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  // last_d_r doubles as the owner of the outstanding access
  logic             last_d_r;
  logic             last_d_nxt_s;
  logic             expire_s;
  logic             open_s;
  logic             pick_d_s;
  logic             gnt_if_s;
  logic             gnt_d_s;
  logic             resp_s;

  always_comb begin
    expire_s = (state_r == ST_WAIT) && (cnt_r == CNT_W'(1));
    open_s   = rst_ni && ((state_r == ST_IDLE) || expire_s);
    // data wins alone, or on contention when fetch was served last
    pick_d_s = d_req_i && (!if_req_i || !last_d_r);
    gnt_d_s  = open_s && pick_d_s;
    gnt_if_s = open_s && if_req_i && !pick_d_s;
    resp_s   = rst_ni && expire_s;
  end

  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    last_d_nxt_s = last_d_r;
    if (gnt_if_s || gnt_d_s) begin
      state_nxt_s  = ST_WAIT;
      cnt_nxt_s    = CNT_W'(MEM_LAT);
      last_d_nxt_s = gnt_d_s;
    end else begin
      case (state_r)
        ST_WAIT: begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
          if (expire_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      last_d_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      last_d_r <= last_d_nxt_s;
    end
  end

  always_comb begin
    if_gnt_o    = gnt_if_s;
    d_gnt_o     = gnt_d_s;
    mem_req_o   = gnt_if_s || gnt_d_s;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_d_s) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (gnt_if_s) begin
      mem_be_o    = 4'hF;
      mem_addr_o  = if_addr_i;
    end else begin
      mem_we_o    = 1'b0;
    end
    if_rvalid_o = resp_s && !last_d_r;
    d_rvalid_o  = resp_s && last_d_r;
    rdata_o     = mem_rdata_i;
    busy_o      = rst_ni && (state_r == ST_WAIT);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: four arbiters (MEM_LAT 1,3,4,8) each driven by queued
// random/directed requests and checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int NL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } req_t;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] data;
    int          due;
  } exp_t;

  function automatic logic [31:0] init_word(int k);
    return 32'hA5C3_0000 ^ (32'(k) * 32'h0001_1111);
  endfunction

  task automatic check(string name, int lat, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s (MEM_LAT=%0d cycle %0d): got %h, want %h", name, lat, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NL; gi++) begin : g_lat
    localparam int L = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 4 : 8;

    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, rdata;
    logic        mem_req, mem_we, busy;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.MEM_LAT(L)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid),
      .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .rdata_o(rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    // Memory environment: 16 words, read data appears L cycles after the strobe
    logic [31:0] env_mem [16];
    logic [31:0] pipe [8];
    assign mem_rdata = pipe[L-1];

    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int k = 0; k < 16; k++) env_mem[k] <= init_word(k);
      end else if (mem_req && mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) env_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      pipe[0] <= (mem_req && !mem_we) ? env_mem[mem_addr[5:2]] : 32'h0BAD_F00D;
      for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
    end

    req_t        if_q[$];
    req_t        d_q[$];
    exp_t        exp_q[$];
    bit          if_gnt_s, d_gnt_s;
    bit          done;
    logic [31:0] model_mem [16];

    // Drivers: hold each request until its grant is seen, honour per-item gaps
    initial begin
      int   if_wait = 0;
      int   d_wait  = 0;
      req_t it;
      if_req = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
      forever begin
        @(posedge clk);
        #1;
        if (if_req && if_gnt_s) if_req = 1'b0;
        if (!if_req && if_q.size() > 0) begin
          if (if_wait < if_q[0].gap) if_wait++;
          else begin
            it = if_q.pop_front();
            if_wait = 0;
            if_req = 1'b1; if_addr = it.addr;
          end
        end
        if (d_req && d_gnt_s) d_req = 1'b0;
        if (!d_req && d_q.size() > 0) begin
          if (d_wait < d_q[0].gap) d_wait++;
          else begin
            it = d_q.pop_front();
            d_wait = 0;
            d_req = 1'b1; d_we = it.we; d_be = it.be; d_addr = it.addr; d_wdata = it.wdata;
          end
        end
      end
    end

    // Reference model + monitor: one access per L cycles, round-robin on contention
    initial begin
      bit   have_last = 1'b0;
      int   last_gnt  = 0;
      bit   last_d    = 1'b0;
      bit   legal, busy_exp;
      int   exp_w, act_w, rv_exp, rv_act;
      exp_t e;
      for (int k = 0; k < 16; k++) model_mem[k] = init_word(k);
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          check("reset_outputs", L,
                {25'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, busy}, 32'd0);
          exp_q.delete();
          have_last = 1'b0; last_d = 1'b0;
          if_gnt_s = 1'b0; d_gnt_s = 1'b0;
        end else begin
          legal    = !have_last || (cyc >= last_gnt + L);
          busy_exp = have_last && (cyc > last_gnt) && (cyc <= last_gnt + L);
          check("busy", L, 32'(busy), 32'(busy_exp));

          rv_act = (d_rvalid ? 2 : 0) + (if_rvalid ? 1 : 0);
          rv_exp = 0;
          if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            rv_exp = e.is_d ? 2 : 1;
            if (!e.we && rv_act == rv_exp) check("rdata", L, rdata, e.data);
          end
          check("rvalid", L, 32'(rv_act), 32'(rv_exp));

          exp_w = 0;
          if (legal) begin
            if (if_req && d_req) exp_w = last_d ? 1 : 2;
            else if (d_req)      exp_w = 2;
            else if (if_req)     exp_w = 1;
          end
          act_w = (d_gnt ? 2 : 0) + (if_gnt ? 1 : 0);
          check("grant", L, 32'(act_w), 32'(exp_w));
          check("mem_req", L, 32'(mem_req), 32'(exp_w != 0));

          if (exp_w == 1) begin
            check("if_mem_addr", L, mem_addr, if_addr);
            check("if_mem_we_be", L, {27'd0, mem_we, mem_be}, 32'h0000_000F);
            exp_q.push_back('{is_d: 1'b0, we: 1'b0, data: model_mem[if_addr[5:2]], due: cyc + L});
          end else if (exp_w == 2) begin
            check("d_mem_addr", L, mem_addr, d_addr);
            check("d_mem_we_be", L, {27'd0, mem_we, mem_be}, {27'd0, d_we, d_be});
            exp_q.push_back('{is_d: 1'b1, we: d_we, data: model_mem[d_addr[5:2]], due: cyc + L});
            if (d_we) begin
              check("d_mem_wdata", L, mem_wdata, d_wdata);
              for (int b = 0; b < 4; b++)
                if (d_be[b]) model_mem[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end
          end else begin
            check("idle_mem_we", L, 32'(mem_we), 32'd0);
          end

          if (exp_w != 0) begin
            have_last = 1'b1; last_gnt = cyc; last_d = (exp_w == 2);
          end
          if_gnt_s = if_gnt;
          d_gnt_s  = d_gnt;
        end
      end
    end

    task automatic drain();
      int n = 0;
      while ((if_q.size() > 0 || d_q.size() > 0 || if_req || d_req || exp_q.size() > 0 || busy)
             && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("drain_in_time", L, 32'(n < 3000), 32'd1);
    endtask

    // Stimulus phases
    initial begin
      req_t r;
      int   n;
      done  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      if_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_0100, wdata: 32'h0, gap: 1});
      drain();

      d_q.push_back('{we: 1'b1, be: 4'b0011, addr: 32'h0000_0200, wdata: 32'hDEAD_BEEF, gap: 0});
      d_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_0200, wdata: 32'h0, gap: 2});
      drain();

      for (int k = 0; k < 2; k++) begin
        if_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h10 + 32'(4*k), wdata: 32'h0, gap: 0});
        d_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h20 + 32'(4*k), wdata: 32'h0, gap: 0});
      end
      drain();

      for (int k = 0; k < 3; k++)
        if_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'(4*k), wdata: 32'h0, gap: 0});
      drain();

      if_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h30, wdata: 32'h0, gap: 0});
      d_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h34, wdata: 32'h0, gap: 0});
      d_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h38, wdata: 32'h0, gap: 0});
      n = 0;
      while (!busy && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("busy_before_reset", L, 32'(busy), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      drain();

      for (int k = 0; k < 80; k++) begin
        r.we = 1'b0; r.be = 4'hF; r.addr = $urandom(); r.wdata = 32'h0;
        r.gap = int'($urandom_range(0, 3));
        if_q.push_back(r);
        r.we = 1'($urandom_range(0, 1)); r.be = 4'($urandom()); r.addr = $urandom();
        r.wdata = $urandom(); r.gap = int'($urandom_range(0, 3));
        d_q.push_back(r);
      end
      drain();
      done = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(g_lat[0].done && g_lat[1].done && g_lat[2].done && g_lat[3].done) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    check("all_instances_done", 0, 32'(n < 60000), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
